// File: rtl/exhaustive_vector_checker.sv
// Exhaustive stimulus sweeper: drives every IN_W-bit vector to a DUT, compares
// its response against a golden model after a settle delay and records errors.
module exhaustive_vector_checker #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 2,
  parameter int MODE   = 0,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_err,
  output logic [IN_W-1:0]  stimulus,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] golden_out,
  output logic             sample_strobe,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IN_W-1:0]  first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int                 CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [IN_W:0]      LAST_IDX = (IN_W + 1)'((64'd1 << IN_W) - 64'd1);
  localparam logic [ERR_W-1:0]   ERR_MAX  = {ERR_W{1'b1}};

  state_t           state_r;
  logic [IN_W:0]    idx_r;
  logic [CNT_W-1:0] cnt_r;

  logic             mismatch_s;
  logic [ERR_W-1:0] err_next_s;
  logic [IN_W:0]    idx_next_s;

  // Sweep order: binary index or its reflected Gray code
  function automatic logic [IN_W-1:0] vec_of(input logic [IN_W-1:0] i);
    if (MODE == 1) begin
      return i ^ (i >> 1);
    end else begin
      return i;
    end
  endfunction

  // Compare result and saturating error-count successor
  always_comb begin
    mismatch_s = 1'b0;
    err_next_s = err_count;
    idx_next_s = idx_r + (IN_W + 1)'(1);
    if (state_r == COMPARE) begin
      mismatch_s = (dut_out != golden_out);
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s && (err_count != ERR_MAX)) begin
      err_next_s = err_count + ERR_W'(1);
    end else begin
      err_next_s = err_count;
    end
  end

  // Sweep sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      idx_r           <= '0;
      cnt_r           <= '0;
      stimulus        <= '0;
      sample_strobe   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          sample_strobe <= 1'b0;
          if (start) begin
            idx_r           <= '0;
            stimulus        <= vec_of(IN_W'(0));
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            cnt_r           <= CNT_LOAD;
            state_r         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == CNT_W'(0)) begin
            sample_strobe <= 1'b1;
            state_r       <= COMPARE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        COMPARE: begin
          sample_strobe <= 1'b0;
          err_count     <= err_next_s;
          if (mismatch_s && !first_err_valid) begin
            first_err_vec   <= stimulus;
            first_err_valid <= 1'b1;
          end
          if ((idx_r == LAST_IDX) || (mismatch_s && stop_on_err)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (err_next_s == ERR_W'(0));
            state_r <= DONE;
          end else begin
            idx_r    <= idx_next_s;
            stimulus <= vec_of(idx_next_s[IN_W-1:0]);
            cnt_r    <= CNT_LOAD;
            state_r  <= WAIT;
          end
        end
        default: begin
          sample_strobe <= 1'b0;
          busy          <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exhaustive_vector_checker.md
Name: exhaustive_vector_checker

Overview:
Synthesizable, self-checking test harness for the lab combinational circuits. It sweeps every IN_W-bit input vector into a device under test (DUT). After a settle delay it compares the DUT output against a golden-model output. It counts mismatches and records the first failing vector. It replaces manual console inspection and can also run on the board, with results shown on LEDs or displays.

Parameters:
IN_W, 4, width of the stimulus vector driven to the DUT; the sweep covers 2^IN_W vectors
OUT_W, 4, width of the DUT and golden outputs
SETTLE, 2, cycles each vector is held before comparison; legal range is SETTLE >= 1
MODE, 0, sweep order: 0 = binary ascending, 1 = Gray code (stimulus = idx ^ (idx >> 1))
ERR_W, 8, width of the saturating mismatch counter

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  level-sampled; begins a sweep when the block is in IDLE or DONE
stop_on_err  in  1  when 1, the sweep ends at the first mismatch
stimulus  out  IN_W  vector driven to the DUT inputs
dut_out  in  OUT_W  DUT response
golden_out  in  OUT_W  golden-model response to the same stimulus
sample_strobe  out  1  high during each compare cycle
busy  out  1  high while a sweep is running
done  out  1  high in DONE; holds until the next start or reset
pass  out  1  valid while done=1; equals (err_count == 0)
err_count  out  ERR_W  number of mismatches in the current/last sweep; saturates at 2^ERR_W-1
first_err_vec  out  IN_W  stimulus value of the first mismatch
first_err_valid  out  1  high once first_err_vec has been captured

Behaviour:
- Reset (asynchronous, rst_n=0): state goes to IDLE. All outputs are 0. The internal index and settle counter are 0. Reset asserted mid-sweep aborts immediately with no partial result retained.
- States: IDLE, WAIT, COMPARE, DONE.
- IDLE or DONE with start=1 at an edge:
  - idx=0; stimulus=f(0).
  - err_count, first_err_vec, first_err_valid, done and pass are cleared.
  - busy=1; settle counter loaded with SETTLE-1; go to WAIT.
- WAIT: the counter decrements each edge. At the edge where it equals 0, go to COMPARE. Stimulus is stable throughout.
- COMPARE (one cycle):
  - sample_strobe=1; mismatch = (dut_out != golden_out), all OUT_W bits compared.
  - On a mismatch edge, err_count increments unless it is already saturated.
  - On a mismatch edge, if first_err_valid=0: first_err_vec <= stimulus and first_err_valid <= 1.
  - If idx == 2^IN_W-1, or (mismatch and stop_on_err): go to DONE. At that edge done <= 1, busy <= 0, and pass <= (err_count_next == 0).
  - Otherwise: idx++, stimulus <= f(idx+1), counter reloaded with SETTLE-1, go to WAIT.
- f(i) = i when MODE=0; f(i) = i ^ (i >> 1) when MODE=1. Index arithmetic is IN_W+1 bits wide, so the terminal compare never wraps.
- Timing: each vector is held for SETTLE+1 cycles. A full sweep asserts done exactly 2^IN_W*(SETTLE+1) edges after the edge that samples start.
- DONE: stimulus holds its last value and all results hold. A new start restarts the sweep from vector 0.
- start while busy=1 is ignored. Changes to stop_on_err take effect at the next COMPARE cycle.
- pass is 0 whenever done=0.

Test Plan:
- Full sweep, dut_out tied to golden_out (IN_W=4, SETTLE=2, MODE=0) -> done rises 48 edges after start, pass=1, err_count=0, first_err_valid=0, sample_strobe pulses 16 times.
- Mismatch injected only when stimulus=5 and 11, stop_on_err=0 -> err_count=2, first_err_vec=5, first_err_valid=1, pass=0, done after 48 edges.
- Same injection at 5 with stop_on_err=1 -> done at edge 18 (6*3), stimulus holds 5, err_count=1.
- MODE=1 -> stimulus sequence 0,1,3,2,6,7,5,4,12,... with exactly one bit changing per step; the last vector is 8.
- ERR_W=3, golden_out = ~dut_out for all vectors -> err_count saturates at 7 (no wrap), first_err_vec=0.
- rst_n pulsed low at vector 7 mid-WAIT -> all outputs 0 immediately. start pulsed during busy has no effect. A new start after reset produces a clean full sweep with pass=1.
